lc3_mem_mmio_ctrl: RTL and testbench

//  Parametrised LC-3 memory subsystem: single-port word RAM plus memory-mapped keyboard/display registers.

---
 rtl/lc3_mem_pkg.sv | 21 ++
 rtl/lc3_mem_mmio_ctrl_if.sv | 24 ++
 rtl/lc3_sram_core.sv | 26 ++
 rtl/lc3_mem_mmio_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lc3_mem_mmio_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared constants and types for the LC-3 memory/MMIO subsystem.
package lc3_mem_pkg;

  // Word offsets inside the 4-word MMIO window.
  localparam logic [1:0] KBDR_OFF = 2'd0;
  localparam logic [1:0] KBSR_OFF = 2'd1;
  localparam logic [1:0] DDR_OFF  = 2'd2;
  localparam logic [1:0] DSR_OFF  = 2'd3;

  // Status register bit positions.
  localparam int unsigned RDY_BIT = 15;
  localparam int unsigned IE_BIT  = 14;

  // Access sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/lc3_mem_mmio_ctrl_if.sv
// Requester-side memory bus: MAR/MDR request with a one-cycle ready pulse back.
interface lc3_mem_mmio_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
) ();

  logic              mem_en;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              ready;

  modport master (
    output mem_en, rw, addr, data_in,
    input  data_out, ready
  );

  modport slave (
    input  mem_en, rw, addr, data_in,
    output data_out, ready
  );

endinterface

// File: rtl/lc3_sram_core.sv
// Synchronous single-port word RAM with a registered read address.
module lc3_sram_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [$clog2(DEPTH)-1:0] raddr_q;

  // Write port and read-address register; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    raddr_q <= addr;
  end

  assign rdata = mem[raddr_q];

endmodule

// File: rtl/lc3_mem_mmio_ctrl.sv
// LC-3 memory subsystem: word RAM plus keyboard/display registers behind a wait-state sequencer.
module lc3_mem_mmio_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = 'h03F0,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  lc3_mem_mmio_ctrl_if.slave bus,
  input  logic              kbd_valid,
  input  logic [DATA_W-1:0] kbd_data,
  output logic              kbd_ready,
  output logic              kbd_irq,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              disp_ack,
  output logic              disp_irq
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  function automatic logic [IDX_W-1:0] ram_index(input logic [ADDR_W-1:0] a);
    return IDX_W'(32'(a) % DEPTH);
  endfunction

  state_e            state_q;
  logic [3:0]        wait_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              kbsr_rdy_q, kbsr_ie_q;
  logic              dsr_rdy_q, dsr_ie_q;
  logic [DATA_W-1:0] kbdr_q, ddr_q;
  logic              disp_valid_q;

  logic              accept, done;
  logic [ADDR_W-1:0] mmio_delta;
  logic              mmio_hit;
  logic [1:0]        mmio_off;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_val;
  logic              kbdr_rd_done, kbsr_wr, ddr_accept, dsr_wr;

  assign accept = (state_q == StIdle) && bus.mem_en;
  assign done   = (state_q == StDone);

  // Modular subtraction keeps the window check correct even near the top of the address space.
  assign mmio_delta = addr_q - MMIO_BASE;
  assign mmio_hit   = (mmio_delta[ADDR_W-1:2] == '0);
  assign mmio_off   = mmio_delta[1:0];

  // Present the incoming address on the accept edge so read data is ready by DONE even with no
  // wait states; otherwise hold the latched request address.
  assign ram_addr = accept ? ram_index(bus.addr) : ram_index(addr_q);
  assign ram_we   = rst_n && done && rw_q && !mmio_hit;

  lc3_sram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign kbdr_rd_done = done && !rw_q && mmio_hit && (mmio_off == KBDR_OFF);
  assign kbsr_wr      = done && rw_q && mmio_hit && (mmio_off == KBSR_OFF);
  assign ddr_accept   = done && rw_q && mmio_hit && (mmio_off == DDR_OFF) && dsr_rdy_q;
  assign dsr_wr       = done && rw_q && mmio_hit && (mmio_off == DSR_OFF);

  // Read-data source for the access currently in DONE.
  always_comb begin
    rd_val = '0;
    if (mmio_hit) begin
      unique case (mmio_off)
        KBDR_OFF: rd_val = kbdr_q;
        KBSR_OFF: begin
          rd_val[RDY_BIT] = kbsr_rdy_q;
          rd_val[IE_BIT]  = kbsr_ie_q;
        end
        DDR_OFF:  rd_val = ddr_q;
        DSR_OFF: begin
          rd_val[RDY_BIT] = dsr_rdy_q;
          rd_val[IE_BIT]  = dsr_ie_q;
        end
      endcase
    end else begin
      rd_val = ram_rdata;
    end
  end

  // Request sequencer: latch the request, count wait states, complete with a one-cycle DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wait_q  <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.mem_en) begin
            rw_q    <= bus.rw;
            addr_q  <= bus.addr;
            wdata_q <= bus.data_in;
            if (WAIT_STATES == 0) begin
              state_q <= StDone;
            end else begin
              state_q <= StWait;
              wait_q  <= WAIT_LOAD;
            end
          end
        end
        StWait: begin
          if (wait_q == 4'd0) begin
            state_q <= StDone;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          if (!rw_q) begin
            rdata_q <= rd_val;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Keyboard and display registers; a completing KBDR read beats a same-cycle keystroke.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kbsr_rdy_q   <= 1'b0;
      kbsr_ie_q    <= 1'b0;
      kbdr_q       <= '0;
      ddr_q        <= '0;
      dsr_rdy_q    <= 1'b1;
      dsr_ie_q     <= 1'b0;
      disp_valid_q <= 1'b0;
    end else begin
      disp_valid_q <= ddr_accept;
      if (kbdr_rd_done) begin
        kbsr_rdy_q <= 1'b0;
      end else if (kbd_valid && !kbsr_rdy_q) begin
        kbdr_q     <= kbd_data;
        kbsr_rdy_q <= 1'b1;
      end
      if (kbsr_wr) begin
        kbsr_ie_q <= wdata_q[IE_BIT];
      end
      if (ddr_accept) begin
        ddr_q     <= wdata_q;
        dsr_rdy_q <= 1'b0;
      end else if (disp_ack && !dsr_rdy_q) begin
        dsr_rdy_q <= 1'b1;
      end
      if (dsr_wr) begin
        dsr_ie_q <= wdata_q[IE_BIT];
      end
    end
  end

  assign bus.ready    = done;
  assign bus.data_out = (done && !rw_q) ? rd_val : rdata_q;
  assign kbd_ready    = !kbsr_rdy_q;
  assign kbd_irq      = kbsr_rdy_q && kbsr_ie_q;
  assign disp_data    = ddr_q;
  assign disp_valid   = disp_valid_q;
  assign disp_irq     = dsr_rdy_q && dsr_ie_q;

endmodule

// File: tb/tb_lc3_mem_mmio_ctrl.sv
// Scoreboard bench: driver pushes expected responses from a behavioural model; monitors pop on ready.
module tb_lc3_mem_mmio_ctrl;

  localparam int unsigned WS    = 3;
  localparam int unsigned DEPTH = 1024;
  localparam logic [15:0] BASE  = 16'h03F0;

  typedef struct {
    bit          rd;
    logic [15:0] data;
    bit          dv;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        kbd_valid, kbd_ready, kbd_irq, disp_valid, disp_ack, disp_irq;
  logic [15:0] kbd_data, disp_data;
  logic        z_valid, z_ack, z_kready, z_kirq, z_dvalid, z_dirq;
  logic [15:0] z_kdata, z_ddata;

  lc3_mem_mmio_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus3 ();
  lc3_mem_mmio_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();

  lc3_mem_mmio_ctrl #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .MMIO_BASE(BASE), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus3),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ready(kbd_ready), .kbd_irq(kbd_irq),
    .disp_data(disp_data), .disp_valid(disp_valid), .disp_ack(disp_ack), .disp_irq(disp_irq)
  );

  lc3_mem_mmio_ctrl #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .MMIO_BASE(BASE), .WAIT_STATES(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .kbd_valid(z_valid), .kbd_data(z_kdata), .kbd_ready(z_kready), .kbd_irq(z_kirq),
    .disp_data(z_ddata), .disp_valid(z_dvalid), .disp_ack(z_ack), .disp_irq(z_dirq)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q3[$];
  exp_t q0[$];
  bit   dv_exp = 1'b0;

  // Reference model state.
  logic [15:0] m_ram [int];
  bit          m_kb_full, m_kb_ie, m_dsr_rdy, m_dsr_ie;
  logic [15:0] m_kbdr, m_ddr;
  logic [15:0] written[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_kb_full = 0; m_kb_ie = 0; m_kbdr = 16'h0;
    m_ddr = 16'h0; m_dsr_rdy = 1; m_dsr_ie = 0;
  endfunction

  // One access at transaction level: returns read value and whether a display pulse follows.
  function automatic void model(input bit w, input logic [15:0] a, input logic [15:0] d,
                                output logic [15:0] rv, output bit dv);
    int off;
    rv = 16'h0;
    dv = 0;
    if (a >= BASE && a <= BASE + 16'd3) begin
      off = int'(a - BASE);
      case (off)
        0: if (!w) begin rv = m_kbdr; m_kb_full = 0; end
        1: if (w) m_kb_ie = d[14]; else rv = {m_kb_full, m_kb_ie, 14'h0};
        2: begin
          if (!w) rv = m_ddr;
          else if (m_dsr_rdy) begin m_ddr = d; m_dsr_rdy = 0; dv = 1; end
        end
        default: if (w) m_dsr_ie = d[14]; else rv = {m_dsr_rdy, m_dsr_ie, 14'h0};
      endcase
    end else if (w) begin
      m_ram[int'(a) % DEPTH] = d;
    end else begin
      rv = m_ram[int'(a) % DEPTH];
    end
  endfunction

  // Monitor for the wait-state DUT: latency, read data and display pulse timing.
  always @(negedge clk) begin
    exp_t e;
    if (dv_exp || disp_valid) chk("disp_valid pulse", disp_valid, dv_exp);
    dv_exp = 0;
    if (bus3.ready) begin
      if (q3.size() == 0) begin
        chk("unexpected ready", bus3.ready, 1'b0);
      end else begin
        e = q3.pop_front();
        chk("latency ws3", cyc - e.acc, WS);
        if (e.rd) chk("read data", bus3.data_out, e.data);
        dv_exp = e.dv;
      end
    end
  end

  // Monitor for the zero-wait-state DUT.
  always @(negedge clk) begin
    exp_t e;
    if (bus0.ready) begin
      if (q0.size() == 0) begin
        chk("unexpected ready ws0", bus0.ready, 1'b0);
      end else begin
        e = q0.pop_front();
        chk("latency ws0", cyc - e.acc, 0);
        if (e.rd) chk("read data ws0", bus0.data_out, e.data);
      end
    end
  end

  task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d,
                        input bit scramble, input bit coincide, input logic [15:0] kd);
    exp_t e;
    logic [15:0] rv;
    bit dv;
    int n;
    @(negedge clk);
    model(w, a, d, rv, dv);
    e.rd = !w; e.data = rv; e.dv = dv; e.acc = cyc + 1;
    q3.push_back(e);
    bus3.mem_en = 1'b1; bus3.rw = w; bus3.addr = a; bus3.data_in = d;
    @(negedge clk);
    if (scramble) begin
      bus3.addr = 16'($urandom);
      bus3.data_in = 16'($urandom);
    end
    n = 0;
    while (!bus3.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus3.ready) begin
      chk("ready timeout", bus3.ready, 1'b1);
      q3.delete();
    end
    if (coincide) begin
      kbd_valid = 1'b1;
      kbd_data = kd;
    end
    bus3.mem_en = 1'b0;
    if (coincide) begin
      @(negedge clk);
      kbd_valid = 1'b0;
    end
  endtask

  task automatic acc0(input bit w, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp_rd);
    exp_t e;
    int n;
    @(negedge clk);
    e.rd = !w; e.data = exp_rd; e.dv = 0; e.acc = cyc + 1;
    q0.push_back(e);
    bus0.mem_en = 1'b1; bus0.rw = w; bus0.addr = a; bus0.data_in = d;
    @(negedge clk);
    n = 0;
    while (!bus0.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus0.ready) begin
      chk("ready timeout ws0", bus0.ready, 1'b1);
      q0.delete();
    end
    bus0.mem_en = 1'b0;
  endtask

  task automatic kbd_push(input logic [15:0] d);
    @(negedge clk);
    kbd_valid = 1'b1; kbd_data = d;
    if (!m_kb_full) begin m_kbdr = d; m_kb_full = 1; end
    @(negedge clk);
    kbd_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    disp_ack = 1'b1;
    if (!m_dsr_rdy) m_dsr_rdy = 1;
    @(negedge clk);
    disp_ack = 1'b0;
  endtask

  task automatic check_dev();
    @(negedge clk);
    chk("kbd_ready", kbd_ready, !m_kb_full);
    chk("kbd_irq", kbd_irq, m_kb_full & m_kb_ie);
    chk("disp_irq", disp_irq, m_dsr_rdy & m_dsr_ie);
    chk("disp_data", disp_data, m_ddr);
  endtask

  initial begin
    logic [15:0] a, d;
    int r;
    rst_n = 1'b0;
    kbd_valid = 0; kbd_data = 0; disp_ack = 0;
    z_valid = 0; z_kdata = 0; z_ack = 0;
    bus3.mem_en = 0; bus3.rw = 0; bus3.addr = 0; bus3.data_in = 0;
    bus0.mem_en = 0; bus0.rw = 0; bus0.addr = 0; bus0.data_in = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    chk("reset ready", bus3.ready, 1'b0);
    chk("reset data_out", bus3.data_out, 16'h0);
    chk("reset disp_valid", disp_valid, 1'b0);
    check_dev();
    access(0, BASE + 16'd3, 16'h0, 0, 0, 16'h0);

    // Zero wait states: write then read back.
    acc0(1, 16'h0010, 16'h1234, 16'h0);
    acc0(0, 16'h0010, 16'h0, 16'h1234);

    // Wait states with address scrambled mid-wait.
    access(1, 16'h0000, 16'h5A5A, 1, 0, 16'h0);
    access(0, 16'h0000, 16'h0, 1, 0, 16'h0);
    access(1, 16'h0001, 16'h0101, 0, 0, 16'h0);
    @(negedge clk);
    chk("data_out held", bus3.data_out, 16'h5A5A);

    // Keyboard.
    kbd_push(16'h0041);
    access(0, BASE + 16'd1, 16'h0, 0, 0, 16'h0);
    check_dev();
    kbd_push(16'h0055);
    access(0, BASE, 16'h0, 0, 0, 16'h0);
    access(0, BASE + 16'd1, 16'h0, 0, 0, 16'h0);
    check_dev();

    // Display.
    access(1, BASE + 16'd2, 16'h0042, 0, 0, 16'h0);
    check_dev();
    access(0, BASE + 16'd3, 16'h0, 0, 0, 16'h0);
    access(1, BASE + 16'd2, 16'h0043, 0, 0, 16'h0);
    check_dev();
    ack_pulse();
    access(0, BASE + 16'd3, 16'h0, 0, 0, 16'h0);

    // Interrupts.
    access(1, BASE + 16'd1, 16'h4000, 0, 0, 16'h0);
    kbd_push(16'h0061);
    check_dev();
    access(0, BASE, 16'h0, 0, 0, 16'h0);
    check_dev();
    access(1, BASE + 16'd3, 16'h4000, 0, 0, 16'h0);
    check_dev();

    // Keystroke coincident with a completing KBDR read is lost.
    kbd_push(16'h0062);
    access(0, BASE, 16'h0, 0, 1, 16'h0077);
    check_dev();
    access(0, BASE + 16'd1, 16'h0, 0, 0, 16'h0);

    // Reset during the wait of a write abandons it.
    access(1, 16'h0020, 16'h1111, 0, 0, 16'h0);
    written.push_back(16'h0020);
    @(negedge clk);
    bus3.mem_en = 1; bus3.rw = 1; bus3.addr = 16'h0020; bus3.data_in = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus3.mem_en = 0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("rst ready", bus3.ready, 1'b0);
    chk("rst data_out", bus3.data_out, 16'h0);
    chk("rst disp_valid", disp_valid, 1'b0);
    check_dev();
    repeat (6) @(negedge clk);
    access(0, 16'h0020, 16'h0, 0, 0, 16'h0);
    access(0, BASE + 16'd3, 16'h0, 0, 0, 16'h0);

    // Randomised mix against the model.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        a = 16'($urandom);
        d = 16'($urandom);
        if (!(a >= BASE && a <= BASE + 16'd3)) written.push_back(a);
        access(1, a, d, 1'($urandom_range(0, 1)), 0, 16'h0);
      end else if (r <= 4 && written.size() > 0) begin
        a = written[$urandom_range(0, written.size() - 1)];
        a = a + 16'(1024 * $urandom_range(0, 63));
        access(0, a, 16'h0, 1'($urandom_range(0, 1)), 0, 16'h0);
      end else if (r <= 6) begin
        a = BASE + 16'($urandom_range(0, 3));
        d = 16'($urandom);
        access(1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 1)), 0, 16'h0);
      end else if (r == 7) begin
        kbd_push(16'($urandom));
      end else if (r == 8) begin
        ack_pulse();
      end else begin
        check_dev();
      end
    end
    check_dev();
    repeat (4) @(negedge clk);
    chk("queue drained", q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
